// File: rtl/task_arb_pkg.sv
// rtl/task_arb_pkg.sv - shared types and helpers for the task stream arbiter
package task_arb_pkg;

    typedef enum logic [1:0] {
        s_IDLE  = 2'd0,
        s_XFER  = 2'd1,
        s_FLUSH = 2'd2
    } task_arb_state_e;

    // Beat counter must be able to hold the value MAX_WORDS itself
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/task_rr_picker.sv
// rtl/task_rr_picker.sv - combinational round-robin pick from ptr+1 upward, wrapping
module task_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // First set request after the last winner gets the one-hot grant
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/task_stream_arbiter.sv
// rtl/task_stream_arbiter.sv - round-robin frame arbiter for one task stream; optional stall timeout via TASK_ARB_TIMEOUT_EN
module task_stream_arbiter
    import task_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_WORDS      = 243,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic                  i_tdata_valid,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tdata_last,
    output logic                  o_tready,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_tdata_valid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic [NUM_REQ-1:0]    o_tdata_last,
    output logic                  o_frame_err,
    output logic                  o_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_WORDS);

    localparam logic [1:0] ST_IDLE  = s_IDLE;
    localparam logic [1:0] ST_XFER  = s_XFER;
    localparam logic [1:0] ST_FLUSH = s_FLUSH;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_err_q, frame_err_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic               tready;
    logic               beat;
    logic               cnt_full;
    logic               in_xfer;

    task_rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (pick),
        .any (pick_any)
    );

    // Binary index of the picked requester, kept alongside the one-hot grant
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // Upstream ready: follows the granted requester in XFER, always open while flushing
    always_comb begin
        tready = 1'b0;
        case (state_q)
            ST_XFER:  tready = i_req[gidx_q];
            ST_FLUSH: tready = 1'b1;
            default:  tready = 1'b0;
        endcase
    end

    assign beat     = i_tdata_valid & tready;
    assign cnt_full = (cnt_q == CNT_W'(MAX_WORDS - 1));
    assign in_xfer  = (state_q == ST_XFER);

    assign o_tready      = tready;
    assign o_gnt         = gnt_q;
    assign o_tdata       = i_tdata;
    assign o_tdata_valid = (in_xfer && beat) ? gnt_q : '0;
    assign o_tdata_last  = (in_xfer && beat && (i_tdata_last || cnt_full)) ? gnt_q : '0;
    assign o_frame_err   = frame_err_q;

`ifdef TASK_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // Frame sequencing: grant in IDLE, count beats in XFER, drain a truncated frame in FLUSH
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
`ifdef TASK_ARB_TIMEOUT_EN
        idle_d      = '0;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    gnt_d   = pick;
                    gidx_d  = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    if (i_tdata_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = gidx_q;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end else if (cnt_full) begin
                        state_d     = ST_FLUSH;
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef TASK_ARB_TIMEOUT_EN
                // Stall watchdog: abandon the frame once no beat has moved for too long
                else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_FLUSH;
                    timeout_d = 1'b1;
                    ptr_d     = gidx_q;
                    cnt_d     = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
`endif
            end
            ST_FLUSH: begin
                if (i_tdata_valid && i_tdata_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = gidx_q;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; reset hands first priority to requester 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
`ifdef TASK_ARB_TIMEOUT_EN
            idle_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
`ifdef TASK_ARB_TIMEOUT_EN
            idle_q      <= idle_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_task_stream_arbiter.sv
// tb/tb_task_stream_arbiter.sv - directed self-checking bench for task_stream_arbiter
module tb_task_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic       o_tready;
    logic [3:0] o_gnt;
    logic [3:0] o_tdata_valid;
    logic [7:0] o_tdata;
    logic [3:0] o_tdata_last;
    logic       o_frame_err;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task_stream_arbiter #(
        .NUM_REQ        (4),
        .DATA_WIDTH     (8),
        .MAX_WORDS      (243),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_tdata_valid (tv),
        .i_tdata       (td),
        .i_tdata_last  (tl),
        .o_tready      (o_tready),
        .o_gnt         (o_gnt),
        .o_tdata_valid (o_tdata_valid),
        .o_tdata       (o_tdata),
        .o_tdata_last  (o_tdata_last),
        .o_frame_err   (o_frame_err),
        .o_timeout     (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while requester g holds the grant; returns at the negedge after the last beat
    task automatic send_frame(input int n, input logic [7:0] base, input int g);
        for (int k = 0; k < n; k++) begin
            tv = 1'b1;
            td = base + 8'(k);
            tl = (k == n - 1);
            #1;
            chk("frm_valid", 32'(o_tdata_valid), 32'(4'b0001 << g));
            chk("frm_last",  32'(o_tdata_last),  (k == n - 1) ? 32'(4'b0001 << g) : 32'd0);
            chk("frm_data",  32'(o_tdata),       32'(base + 8'(k)));
            @(negedge clk);
        end
        tv = 1'b0;
        tl = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"},    32'(o_gnt), 32'd0);
        chk({tag, "_tready"}, 32'(o_tready), 32'd0);
        chk({tag, "_valid"},  32'(o_tdata_valid), 32'd0);
        chk({tag, "_last"},   32'(o_tdata_last), 32'd0);
        chk({tag, "_ferr"},   32'(o_frame_err), 32'd0);
        chk({tag, "_tout"},   32'(o_timeout), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0101;
        tv    = 1'b0;
        td    = 8'h00;
        tl    = 1'b0;

        // 1: reset state, then req=0101 and a 3-beat frame to requester 0
        @(negedge clk);
        @(negedge clk);
        #1;
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_gnt_latency", 32'(o_gnt), 32'd0);
        @(negedge clk);
        chk("t1_gnt", 32'(o_gnt), 32'b0001);
        send_frame(3, 8'hA1, 0);
        chk("t1_bubble", 32'(o_gnt), 32'd0);
        @(negedge clk);
        chk("t1_next_gnt", 32'(o_gnt), 32'b0100);
        send_frame(1, 8'hB0, 2);

        // 2: reset, all requests held, grant order 0,1,2,3,0 with a 1-cycle bubble
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        #1;
        check_idle_outputs("rst2");
        rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            chk("t2_gnt", 32'(o_gnt), 32'(4'b0001 << f));
            send_frame(2, 8'h20 + 8'(f * 2), f);
            chk("t2_bubble", 32'(o_gnt), 32'd0);
            @(negedge clk);
        end
        chk("t2_wrap_gnt", 32'(o_gnt), 32'b0001);

        // 3: granted requester 0 drops its request for 5 cycles mid-frame
        tv = 1'b1; td = 8'h30; tl = 1'b0;
        #1;
        chk("t3_beat1", 32'(o_tdata_valid), 32'b0001);
        @(negedge clk);
        req = 4'b1110;
        td  = 8'h31;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_tready", 32'(o_tready), 32'd0);
            chk("t3_stall_valid",  32'(o_tdata_valid), 32'd0);
            chk("t3_stall_gnt",    32'(o_gnt), 32'b0001);
            @(negedge clk);
        end
        req = 4'b1111;
        tl  = 1'b1;
        #1;
        chk("t3_resume_valid", 32'(o_tdata_valid), 32'b0001);
        chk("t3_resume_last",  32'(o_tdata_last), 32'b0001);
        chk("t3_resume_data",  32'(o_tdata), 32'h31);
        @(negedge clk);
        tv = 1'b0; tl = 1'b0;
        chk("t3_bubble", 32'(o_gnt), 32'd0);
        @(negedge clk);

        // 4: 247-beat frame to requester 1, truncated at beat 243, 4 beats flushed
        chk("t4_gnt", 32'(o_gnt), 32'b0010);
        for (int k = 0; k < 247; k++) begin
            tv = 1'b1;
            td = 8'(k);
            tl = (k == 246);
            #1;
            chk("t4_tready", 32'(o_tready), 32'd1);
            chk("t4_valid",  32'(o_tdata_valid), (k < 243) ? 32'b0010 : 32'd0);
            chk("t4_last",   32'(o_tdata_last), (k == 242) ? 32'b0010 : 32'd0);
            chk("t4_ferr",   32'(o_frame_err), (k == 243) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        tv = 1'b0; tl = 1'b0;
        chk("t4_bubble", 32'(o_gnt), 32'd0);
        @(negedge clk);
        chk("t4_next_gnt", 32'(o_gnt), 32'b0100);

        // 5: reset on beat 2 of a frame to requester 2
        tv = 1'b1; td = 8'h50; tl = 1'b0;
        #1;
        chk("t5_beat1", 32'(o_tdata_valid), 32'b0100);
        @(negedge clk);
        td    = 8'h51;
        rst_n = 1'b0;
        @(negedge clk);
        tv = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_gnt_after_rst", 32'(o_gnt), 32'b0001);
        send_frame(1, 8'h55, 0);
        @(negedge clk);
        chk("t6_gnt", 32'(o_gnt), 32'b0010);

        // 6: stall of valid after beat 1 for 16 cycles
        tv = 1'b1; td = 8'h60; tl = 1'b0;
        #1;
        chk("t6_beat1", 32'(o_tdata_valid), 32'b0010);
        @(negedge clk);
        tv = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            #1;
`ifdef TASK_ARB_TIMEOUT_EN
            chk("t6_timeout", 32'(o_timeout), (j == 16) ? 32'd1 : 32'd0);
`else
            chk("t6_timeout", 32'(o_timeout), 32'd0);
`endif
        end
        tv = 1'b1; td = 8'h61; tl = 1'b1;
        #1;
        chk("t6_tready", 32'(o_tready), 32'd1);
`ifdef TASK_ARB_TIMEOUT_EN
        chk("t6_flush_valid", 32'(o_tdata_valid), 32'd0);
`else
        chk("t6_end_valid", 32'(o_tdata_valid), 32'b0010);
`endif
        @(negedge clk);
        tv = 1'b0; tl = 1'b0;
        chk("t6_bubble", 32'(o_gnt), 32'd0);
        @(negedge clk);
        chk("t6_rotate", 32'(o_gnt), 32'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
